// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the boot-ROM word fetcher: FSM states and word geometry.
package rom_fetch_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/rom_byte_gatherer.sv
// Walks the byte-wide ROM from a base address and packs four bytes little-endian.
module rom_byte_gatherer
  import rom_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          clear,
  input  logic [ADDRESS_WIDTH-1:0]      base,
  input  logic [7:0]                    rom_data,
  output logic [ADDRESS_WIDTH-1:0]      rom_addr,
  output logic                          done,
  output logic [8*BYTES_PER_WORD-1:0]   word
);

  logic             busy;
  logic [CNT_W-1:0] cnt;

  // start/clear win over the capture in flight, so done must not fire with them
  assign done = busy && (cnt == CNT_W'(BYTES_PER_WORD - 1)) && !start && !clear;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy     <= 1'b0;
      cnt      <= '0;
      rom_addr <= '0;
      word     <= '0;
    end else if (clear) begin
      busy <= 1'b0;
      cnt  <= '0;
      word <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      rom_addr <= base;
    end else if (busy) begin
      for (int i = 0; i < BYTES_PER_WORD; i++)
        if (cnt == CNT_W'(i)) word[8*i +: 8] <= rom_data;
      cnt <= cnt + CNT_W'(1);
      // rom_addr parks on the last byte so it holds steady outside FETCH
      if (cnt == CNT_W'(BYTES_PER_WORD - 1)) busy <= 1'b0;
      else rom_addr <= rom_addr + ADDRESS_WIDTH'(1);
    end
  end

endmodule

// File: rtl/rom_word_fetch.sv
// Instruction-fetch front end for the byte-wide boot ROM: req/rsp handshake FSM.
// Optional next-word prefetch buffer enabled by ROM_WORD_FETCH_PREFETCH_EN.
module rom_word_fetch
  import rom_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int XLEN          = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_data,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [7:0]               rom_data
);

  fetch_state_e state;
  logic skip_q;
  logic accept, req_err, skip_now, start, clear, g_done;
  logic [ADDRESS_WIDTH-1:0] req_base, g_base;
  logic [8*BYTES_PER_WORD-1:0] g_word;

  assign req_base  = req_addr[ADDRESS_WIDTH-1:0];
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && (state == ST_IDLE);
  assign req_err   = |(req_addr[1:0] & ALIGN_MASK) || |req_addr[XLEN-1:ADDRESS_WIDTH];
  assign clear     = accept && req_err;
  assign rsp_data  = XLEN'(g_word);

`ifdef ROM_WORD_FETCH_PREFETCH_EN
  logic [ADDRESS_WIDTH-1:0] tag_q;
  logic pf_fill, pf_valid, pf_match, hit_now, pf_start;

  // Only follow a good word whose successor still lies inside the ROM
  assign pf_start = (state == ST_RESP) && rsp_ready && !rsp_err &&
                    (tag_q[ADDRESS_WIDTH-1:2] != '1);
  assign pf_match = (pf_fill || pf_valid) && !req_err && (req_base == tag_q);
  assign hit_now  = pf_match && (pf_valid || g_done);
  assign skip_now = req_err || hit_now;
  assign start    = (accept && !req_err && !pf_match) || pf_start;
  assign g_base   = pf_start ? tag_q + ADDRESS_WIDTH'(BYTES_PER_WORD) : req_base;
`else
  assign skip_now = req_err;
  assign start    = accept && !req_err;
  assign g_base   = req_base;
`endif

  rom_byte_gatherer #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_gather (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .clear    (clear),
    .base     (g_base),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .done     (g_done),
    .word     (g_word)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      skip_q  <= 1'b0;
      rsp_err <= 1'b0;
`ifdef ROM_WORD_FETCH_PREFETCH_EN
      tag_q    <= '0;
      pf_fill  <= 1'b0;
      pf_valid <= 1'b0;
`endif
    end else begin
`ifdef ROM_WORD_FETCH_PREFETCH_EN
      if (g_done) begin
        pf_fill  <= 1'b0;
        pf_valid <= pf_fill;
      end
      if (pf_start) begin
        pf_fill  <= 1'b1;
        pf_valid <= 1'b0;
        tag_q    <= g_base;
      end
`endif
      case (state)
        ST_IDLE: if (accept) begin
          rsp_err <= req_err;
          skip_q  <= skip_now;
          state   <= ST_FETCH;
`ifdef ROM_WORD_FETCH_PREFETCH_EN
          // Any request consumes or invalidates the buffer entry
          tag_q    <= req_base;
          pf_fill  <= 1'b0;
          pf_valid <= 1'b0;
`endif
        end
        // skip_q: error or buffered word, one cycle here without touching the ROM
        ST_FETCH: if (skip_q || g_done) state <= ST_RESP;
        ST_RESP:  if (rsp_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_word_fetch.sv
// Directed bench for rom_word_fetch with a transaction-level reference model.
module tb_rom_word_fetch;
  localparam int AW   = 8;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [XLEN-1:0] req_addr = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data;

  logic [7:0] rom_img [256];
  assign rom_data = rom_img[rom_addr];

  rom_word_fetch #(.ADDRESS_WIDTH(AW), .XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] img_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {rom_img[b + 8'd3], rom_img[b + 8'd2], rom_img[b + 8'd1], rom_img[b]};
  endfunction

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) rom_img[a + k] = w[8*k +: 8];
  endtask

  // Reference model: per accepted request, the word/error owed and the cycle it is due
  int          cyc = 0;
  bit          m_pend = 0;
  logic [31:0] m_addr, m_word;
  bit          m_err;
  int          m_due;
  bit          pf_ok = 0;
  logic [31:0] pf_addr;
  int          pf_r;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pend = 0;
      pf_ok  = 0;
    end else begin
      cyc++;
      if (rsp_valid && rsp_ready) begin
        m_pend = 0;
        if (!m_err && (m_addr + 4 < 256)) begin
          pf_ok   = 1;
          pf_addr = m_addr + 4;
          pf_r    = cyc;
        end
      end else if (req_valid && req_ready) begin
        int lat;
        m_addr = req_addr;
        m_err  = (req_addr % 4 != 0) || (req_addr >= 256);
        m_word = m_err ? 32'h0 : img_word(req_addr);
        lat    = m_err ? 1 : 4;
`ifdef ROM_WORD_FETCH_PREFETCH_EN
        // prefetch started at the handshake edge and needs four edges to fill
        if (!m_err && pf_ok && req_addr == pf_addr)
          lat = (pf_r + 4 - cyc > 1) ? pf_r + 4 - cyc : 1;
`endif
        pf_ok  = 0;
        m_due  = cyc + lat;
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      bit exp_v;
      exp_v = m_pend && (cyc >= m_due);
      chk("req_ready", req_ready, !m_pend);
      chk("rsp_valid", rsp_valid, exp_v);
      if (rsp_valid && exp_v) begin
        chk("rsp_data", rsp_data, m_word);
        chk("rsp_err", rsp_err, m_err);
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int idle, input int hold,
                       output int lat, output logic [31:0] d, output logic e);
    int n;
    repeat (idle) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("rsp_seen", rsp_valid, 1);
    d = rsp_data;
    e = rsp_err;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, d);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] d;
    logic e;
    logic [AW-1:0] ra;

    for (int i = 0; i < 256; i++) rom_img[i] = 8'(i * 37 + 11);
    put_word(8'h00, 32'h000107B7);
    put_word(8'h04, 32'h07878793);
    put_word(8'h10, 32'h00E68023);
    put_word(8'h20, 32'h00008067);
    put_word(8'h24, 32'h6C6C6548);
    put_word(8'h40, 32'h00000000);
    put_word(8'h54, 32'h000107B7);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    #2 resetn = 1'b1;

    fetch(32'h00, 0, 0, lat, d, e);
    chk("w00_data", d, 32'h000107B7);
    chk("w00_err", e, 0);
    chk("w00_lat", lat, 4);

    fetch(32'h24, 0, 0, lat, d, e);
    chk("w24_data", d, 32'h6C6C6548);
    fetch(32'h20, 0, 0, lat, d, e);
    chk("w20_data", d, 32'h00008067);
    chk("w20_lat", lat, 4);

    ra = rom_addr;
    fetch(32'h02, 0, 0, lat, d, e);
    chk("w02_err", e, 1);
    chk("w02_data", d, 0);
    chk("w02_lat", lat, 1);
    chk("w02_rom_addr", rom_addr, ra);

    fetch(32'h100, 0, 0, lat, d, e);
    chk("w100_err", e, 1);
    chk("w100_lat", lat, 1);

    fetch(32'h10, 0, 3, lat, d, e);
    chk("w10_data", d, 32'h00E68023);
    chk("w10_lat", lat, 4);

    // reset in the middle of a fetch, two bytes captured
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h54;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    @(negedge clk);
    #2 resetn = 1'b1;
    fetch(32'h54, 0, 0, lat, d, e);
    chk("w54_data", d, 32'h000107B7);
    chk("w54_lat", lat, 4);

`ifdef ROM_WORD_FETCH_PREFETCH_EN
    fetch(32'h00, 0, 0, lat, d, e);
    fetch(32'h04, 5, 0, lat, d, e);
    chk("pf04_data", d, 32'h07878793);
    chk("pf04_lat", lat, 1);
    fetch(32'h00, 0, 0, lat, d, e);
    fetch(32'h40, 0, 0, lat, d, e);
    chk("pf40_data", d, 32'h00000000);
    chk("pf40_lat", lat, 4);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_word_fetch.md
Name: rom_word_fetch

Overview:
- Downstream consumer of the byte-wide combinational boot ROM (8-bit `data`, `ADDRESS_WIDTH`-bit `addr`).
- Assembles four sequential ROM bytes into one little-endian 32-bit instruction word.
- Returns the word to the core's instruction-fetch port over a valid/ready request/response handshake.
- Sits between the RISC-V core fetch stage and the boot ROM; owns the ROM address bus exclusively.

Parameters:
- ADDRESS_WIDTH, 8, width of the ROM byte address; must match the attached ROM.
- XLEN, 32, width of req_addr and rsp_data.

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  core requests a word fetch.
- req_ready  output  1  block can accept a request.
- req_addr  input  XLEN  byte address of the requested word.
- rsp_valid  output  1  response word available.
- rsp_ready  input  1  core accepts the response.
- rsp_data  output  XLEN  assembled word; byte at base is bits [7:0].
- rsp_err  output  1  request was misaligned or out of ROM range.
- rom_addr  output  ADDRESS_WIDTH  byte address driven to the ROM.
- rom_data  input  8  combinational ROM byte for rom_addr.

Behaviour:
- Reset: asynchronous, active-low. State=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, rom_addr=0, byte counter=0.
- FSM states: IDLE, FETCH, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_addr[ADDRESS_WIDTH-1:0] as base.
  - Error check: err = (req_addr[1:0]!=0) || (req_addr[XLEN-1:ADDRESS_WIDTH]!=0).
  - If err: go to RESP with rsp_err=1, rsp_data=0. No ROM access.
  - Otherwise: go to FETCH with cnt=0.
- FETCH:
  - req_ready=0.
  - rom_addr = base + cnt, computed modulo 2^ADDRESS_WIDTH. Aligned, in-range bases never wrap.
  - Each cycle, rom_data is captured into rsp_data[8*cnt +: 8] and cnt increments.
  - After capturing cnt=3, go to RESP with rsp_err=0.
- RESP:
  - rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE with rsp_valid=0.
  - req_ready=0 throughout, so there is no overlap of request and response.
- Latency: request accepted at edge N; rsp_valid is high after edge N+4 for a good fetch, after edge N+1 for an error. Throughput is at most one word per 6 cycles with rsp_ready held high.
- Byte lanes: rsp_data is undefined-free; unfilled lanes keep their previous contents only while in FETCH. The bench checks rsp_data only when rsp_valid=1.
- Reset mid-FETCH or mid-RESP: immediate return to IDLE, rsp_valid drops asynchronously, the partial word is discarded.
- rom_addr in IDLE/RESP holds its last value; the ROM is side-effect free.

Optional Feature:
- Macro: ROM_WORD_FETCH_PREFETCH_EN.
- Defined:
  - After a non-error response completes, the block speculatively fetches base+4 into a one-entry buffer (valid flag, tag) while in IDLE. req_ready stays 1 during the prefetch.
  - Request matching the tag with the buffer complete: go to RESP on the next edge (1-cycle latency).
  - Request matching the tag with the prefetch in progress: continue the fetch, then go to RESP.
  - Non-matching request: abort the prefetch, invalidate the buffer, perform a normal fetch.
  - No prefetch when base+4 is out of range.
- Undefined: no buffer; behaviour exactly as above.

Decomposition:
- Shared package rom_fetch_pkg:
  - FSM state enum (IDLE/FETCH/RESP).
  - Byte-lane count constant BYTES_PER_WORD=4.
  - Alignment mask constant.
- One natural sub-module: rom_byte_gatherer.
  - Contents: cnt, rom_addr generation, lane capture.
  - Interface: start/base in, done/word out.
  - The top level keeps the handshake FSM and the prefetch buffer.

Test Plan:
- req_addr=0x00 with the standard boot image -> rsp_data=0x000107B7, rsp_err=0, rsp_valid asserted 4 cycles after acceptance.
- req_addr=0x24 -> 0x6C6C6548 ("Hell"); req_addr=0x20 -> 0x00008067 (ret).
- req_addr=0x02 -> rsp_err=1, rsp_data=0, rsp_valid 1 cycle after acceptance, no rom_addr change; req_addr=0x100 with ADDRESS_WIDTH=8 -> rsp_err=1.
- req_addr=0x10, rsp_ready held low 3 cycles -> rsp_valid and rsp_data=0x00E68023 stable all 3 cycles; req_ready=0 until rsp_ready.
- resetn pulsed low while cnt=2 fetching 0x54 -> rsp_valid=0 and req_ready=1 immediately; a new fetch of 0x54 returns 0x000107B7.
- With ROM_WORD_FETCH_PREFETCH_EN: fetch 0x00, then 0x04 after 5 idle cycles -> 0x07878793 returned 1 cycle after acceptance; fetch 0x00, then 0x40 -> normal 4-cycle latency, returns 0x00000000.
